// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared definitions for the vending selection decoder.
//                Holds the controller state encoding, the default parameter
//                values used by the top level, and the width of the shared
//                cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
package vend_pkg;

    // Controller states. The width is fixed at two bits so that the
    // encoding is the same in every configuration.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE     = 2'd1,
        WAIT_DONE = 2'd2
    } vend_state_t;

    // Default parameter values for vend_select_decoder.
    localparam int c_def_code_w         = 4;
    localparam int c_def_num_items      = 16;
    localparam int c_def_pulse_cycles   = 8;
    localparam int c_def_timeout_cycles = 1024;
    localparam int c_def_msb_first      = 1;

    // Width of the shared counter. It must hold TIMEOUT_CYCLES-1, which can
    // be as large as 65534, and PULSE_CYCLES-1, which is at most 254.
    localparam int c_cnt_w = 16;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vend_cycle_counter
//  Description : Loadable down-counter with a zero flag. A single instance
//                times both the dispense pulse and the completion timeout.
//                Load has priority over decrement, and the count saturates
//                at zero.
//  Ports       : clk          - clock, rising edge
//                rst          - synchronous active-high reset
//                i_load       - load i_load_value on the next edge
//                i_load_value - value to load
//                i_dec        - decrement by one (ignored while loading)
//                o_zero       - high while the count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module vend_cycle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : vend_cycle_counter
`default_nettype wire

// File: rtl/vend_select_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vend_select_decoder
//  Description : Accepts an item selection code, converts it to a registered
//                one-hot dispense select held for PULSE_CYCLES cycles, and
//                then waits for the mechanism to acknowledge completion, or
//                reports a fault on timeout. An invalid code produces a
//                single-cycle error pulse.
//  Ports       : clk     - clock, rising edge
//                reset   - synchronous active-high reset
//                code    - selection code, sampled on acceptance
//                req     - request valid; accepted when req & ready
//                ready   - high only while idle
//                onehot  - one-hot dispense select (2**CODE_W bits)
//                done_in - completion acknowledge from the mechanism
//                err     - one-cycle pulse after an invalid code is accepted
//                fault   - one-cycle pulse on completion timeout
//  Revision    : 1.0  initial release
// ============================================================================
module vend_select_decoder
    import vend_pkg::*;
#(
    parameter int CODE_W         = c_def_code_w,
    parameter int NUM_ITEMS      = c_def_num_items,
    parameter int PULSE_CYCLES   = c_def_pulse_cycles,
    parameter int TIMEOUT_CYCLES = c_def_timeout_cycles,
    parameter int MSB_FIRST      = c_def_msb_first
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CODE_W-1:0]    code,
    input  logic                 req,
    output logic                 ready,
    output logic [2**CODE_W-1:0] onehot,
    input  logic                 done_in,
    output logic                 err,
    output logic                 fault
);

    localparam int c_oh_w = 2**CODE_W;

    // The counter is loaded with N-1. It then needs N edges to reach zero
    // and move on, so the loaded state lasts exactly N cycles.
    localparam int               c_pulse_load_i   = PULSE_CYCLES - 1;
    localparam int               c_timeout_load_i = TIMEOUT_CYCLES - 1;
    localparam logic [c_cnt_w-1:0] c_pulse_load   = c_pulse_load_i[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_timeout_load = c_timeout_load_i[c_cnt_w-1:0];

    // One extra bit so that NUM_ITEMS == 2**CODE_W is representable.
    localparam int                 c_num_items_i = NUM_ITEMS;
    localparam logic [CODE_W:0]    c_num_items   = c_num_items_i[CODE_W:0];

    vend_state_t         r_state;
    vend_state_t         w_state_nxt;
    logic [c_oh_w-1:0]   r_onehot;
    logic [c_oh_w-1:0]   w_onehot_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                r_fault;
    logic                w_fault_nxt;
    logic                r_ready;
    logic                r_sticky;
    logic                w_sticky_nxt;

    logic [CODE_W-1:0]   w_index;
    logic [c_oh_w-1:0]   w_decoded;
    logic                w_valid;
    logic                w_accept;

    logic                w_cnt_load;
    logic [c_cnt_w-1:0]  w_cnt_load_val;
    logic                w_cnt_dec;
    logic                w_cnt_zero;

    // ------------------------------------------------------------------
    // Code to index. With MSB_FIRST set, code[0] carries the most
    // significant index bit, so the bit order is reversed.
    // ------------------------------------------------------------------
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            for (genvar gi = 0; gi < CODE_W; gi++) begin : g_bit
                assign w_index[CODE_W-1-gi] = code[gi];
            end
        end else begin : g_lsb_first
            assign w_index = code;
        end
    endgenerate

    always_comb begin
        w_decoded          = '0;
        w_decoded[w_index] = 1'b1;
    end

    assign w_valid  = ({1'b0, w_index} < c_num_items);
    assign w_accept = req && r_ready;

    // ------------------------------------------------------------------
    // Shared timer: pulse length in PULSE, timeout budget in WAIT_DONE.
    // ------------------------------------------------------------------
    vend_cycle_counter #(
        .WIDTH (c_cnt_w)
    ) u_cycle_counter (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_load_val),
        .i_dec        (w_cnt_dec),
        .o_zero       (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_onehot_nxt   = r_onehot;
        w_err_nxt      = 1'b0;
        w_fault_nxt    = 1'b0;
        w_sticky_nxt   = r_sticky;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;

        case (r_state)
            IDLE: begin
                // An acknowledge that arrives while idle belongs to no
                // dispense and must not be remembered.
                w_sticky_nxt = 1'b0;
                w_onehot_nxt = '0;
                if (w_accept) begin
                    if (w_valid) begin
                        w_state_nxt    = PULSE;
                        w_onehot_nxt   = w_decoded;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = c_pulse_load;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            PULSE: begin
                // The mechanism may finish early. Remember that so
                // WAIT_DONE only has to spend a single cycle.
                if (done_in) begin
                    w_sticky_nxt = 1'b1;
                end
                if (w_cnt_zero) begin
                    w_state_nxt    = WAIT_DONE;
                    w_onehot_nxt   = '0;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_timeout_load;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end

            WAIT_DONE: begin
                w_onehot_nxt = '0;
                // A completion, whether it arrives now or was remembered,
                // wins over a timeout that falls on the same cycle.
                if (done_in || r_sticky) begin
                    w_state_nxt  = IDLE;
                    w_sticky_nxt = 1'b0;
                end else if (w_cnt_zero) begin
                    w_state_nxt  = IDLE;
                    w_fault_nxt  = 1'b1;
                    w_sticky_nxt = 1'b0;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_onehot_nxt = '0;
                w_sticky_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. The ready output is registered from the
    // next state, so it still equals "state is IDLE" while having no
    // combinational path from the inputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_onehot <= '0;
            r_err    <= 1'b0;
            r_fault  <= 1'b0;
            r_ready  <= 1'b1;
            r_sticky <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_onehot <= w_onehot_nxt;
            r_err    <= w_err_nxt;
            r_fault  <= w_fault_nxt;
            r_ready  <= (w_state_nxt == IDLE);
            r_sticky <= w_sticky_nxt;
        end
    end

    assign ready  = r_ready;
    assign onehot = r_onehot;
    assign err    = r_err;
    assign fault  = r_fault;

endmodule : vend_select_decoder
`default_nettype wire

// File: tb/tb_vend_select_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_select_decoder
//  Description : Self-checking bench for vend_select_decoder. dut_a uses the
//                default parameters. dut_b uses NUM_ITEMS=10,
//                TIMEOUT_CYCLES=4, MSB_FIRST=0 and PULSE_CYCLES=2. Each
//                stimulus step pushes the outputs expected after the next
//                clock edge onto a per-DUT queue, and a monitor pops and
//                compares one entry per edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vend_select_decoder;

    typedef struct packed {
        logic [15:0] onehot;
        logic        ready;
        logic        err;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        reset_a, req_a, done_a;
    logic [3:0]  code_a;
    logic        ready_a, err_a, fault_a;
    logic [15:0] onehot_a;
    logic        reset_b, req_b, done_b;
    logic [3:0]  code_b;
    logic        ready_b, err_b, fault_b;
    logic [15:0] onehot_b;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    vend_select_decoder dut_a (
        .clk     (clk),
        .reset   (reset_a),
        .code    (code_a),
        .req     (req_a),
        .ready   (ready_a),
        .onehot  (onehot_a),
        .done_in (done_a),
        .err     (err_a),
        .fault   (fault_a)
    );

    vend_select_decoder #(
        .CODE_W         (4),
        .NUM_ITEMS      (10),
        .PULSE_CYCLES   (2),
        .TIMEOUT_CYCLES (4),
        .MSB_FIRST      (0)
    ) dut_b (
        .clk     (clk),
        .reset   (reset_b),
        .code    (code_b),
        .req     (req_b),
        .ready   (ready_b),
        .onehot  (onehot_b),
        .done_in (done_b),
        .err     (err_b),
        .fault   (fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare(input string pfx, input exp_t e, input logic [15:0] oh,
                           input logic rdy, input logic er, input logic ft);
        check_val({pfx, "_onehot"},  {16'h0, oh}, {16'h0, e.onehot});
        check_val({pfx, "_ready"},   {31'h0, rdy}, {31'h0, e.ready});
        check_val({pfx, "_err"},     {31'h0, er}, {31'h0, e.err});
        check_val({pfx, "_fault"},   {31'h0, ft}, {31'h0, e.fault});
        check_val({pfx, "_onehot0"}, {31'h0, $onehot0(oh)}, 32'd1);
    endtask

    // Scoreboard monitor: one expectation per edge for each active DUT.
    always @(posedge clk) begin
        exp_t ea;
        exp_t eb;
        #1;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            compare("a", ea, onehot_a, ready_a, err_a, fault_a);
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            compare("b", eb, onehot_b, ready_b, err_b, fault_b);
        end
    end

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic step(input int which, input logic rs, input logic rq, input logic [3:0] cd,
                        input logic dn, input logic [15:0] oh, input logic rdy,
                        input logic er, input logic ft);
        exp_t e;
        @(negedge clk);
        e.onehot = oh;
        e.ready  = rdy;
        e.err    = er;
        e.fault  = ft;
        if (which == 0) begin
            reset_a = rs; req_a = rq; code_a = cd; done_a = dn;
            q_a.push_back(e);
        end else begin
            reset_b = rs; req_b = rq; code_b = cd; done_b = dn;
            q_b.push_back(e);
        end
    endtask

    initial begin
        reset_a = 1'b1; req_a = 1'b0; code_a = 4'h0; done_a = 1'b0;
        reset_b = 1'b1; req_b = 1'b0; code_b = 4'h0; done_b = 1'b0;

        // ---------------- dut_a: defaults ----------------
        step(0, 1, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        step(0, 1, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        // Acknowledge while idle is ignored.
        step(0, 0, 0, 4'h0, 1, 16'h0000, 1, 0, 0);
        // code 0001, MSB-first -> index 8. A second request while busy is ignored.
        step(0, 0, 1, 4'b0001, 0, 16'h0100, 0, 0, 0);
        for (int i = 2; i <= 8; i++)
            step(0, 0, (i == 3), (i == 3) ? 4'b0010 : 4'b0001, 0, 16'h0100, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 4'h0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 4'h0, 1, 16'h0000, 1, 0, 0);
        step(0, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        // Early acknowledge in pulse cycle 3 -> a single WAIT_DONE cycle.
        step(0, 0, 1, 4'b1000, 0, 16'h0002, 0, 0, 0);
        for (int i = 2; i <= 8; i++)
            step(0, 0, 0, 4'h0, (i == 3), 16'h0002, 0, 0, 0);
        step(0, 0, 0, 4'h0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        // Reset in pulse cycle 5 aborts, and takes priority over req and done_in.
        step(0, 0, 1, 4'b1111, 0, 16'h8000, 0, 0, 0);
        for (int i = 2; i <= 5; i++)
            step(0, 0, 0, 4'h0, 0, 16'h8000, 0, 0, 0);
        step(0, 1, 1, 4'b0100, 1, 16'h0000, 1, 0, 0);
        step(0, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        // Normal operation after the abort: code 0100 -> index 2.
        step(0, 0, 1, 4'b0100, 0, 16'h0004, 0, 0, 0);
        for (int i = 2; i <= 8; i++)
            step(0, 0, 0, 4'h0, 0, 16'h0004, 0, 0, 0);
        step(0, 0, 0, 4'h0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 4'h0, 1, 16'h0000, 1, 0, 0);
        step(0, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);

        // ---------------- dut_b: N=10, T=4, LSB order, P=2 ----------------
        step(1, 1, 1, 4'b0001, 0, 16'h0000, 1, 0, 0);
        step(1, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        // Index 12 and index 10 are invalid.
        step(1, 0, 1, 4'b1100, 0, 16'h0000, 1, 1, 0);
        step(1, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        step(1, 0, 1, 4'b1010, 0, 16'h0000, 1, 1, 0);
        // Index 9 is the last valid item. done_in on the timeout cycle wins.
        step(1, 0, 1, 4'b1001, 0, 16'h0200, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 16'h0200, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 4'h0, 0, 16'h0000, 0, 0, 0);
        step(1, 0, 0, 4'h0, 1, 16'h0000, 1, 0, 0);
        step(1, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        // code 0001, LSB order -> index 1. Timeout 4 cycles after WAIT_DONE entry.
        step(1, 0, 1, 4'b0001, 0, 16'h0002, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 16'h0002, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 4'h0, 0, 16'h0000, 0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 1);
        step(1, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);
        step(1, 0, 0, 4'h0, 0, 16'h0000, 1, 0, 0);

        repeat (2) @(negedge clk);
        check_val("a_queue_drain", q_a.size(), 32'd0);
        check_val("b_queue_drain", q_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vend_select_decoder
`default_nettype wire
